// File: rtl/pcs_symbols_pkg.sv
// Shared PCS symbol vocabulary: K-codes, scheduler state and grant encodings.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pcs_symbols_pkg;

   // K-codes, shared with the receive demux classifier
   localparam logic [7:0] K_COM  = 8'hBC;
   localparam logic [7:0] K_STP  = 8'hFB;
   localparam logic [7:0] K_SDP  = 8'h5C;
   localparam logic [7:0] K_SKP  = 8'h1C;
   localparam logic [7:0] K_END  = 8'hFD;
   localparam logic [7:0] K_EDB  = 8'hFE;
   localparam logic [7:0] K_IDLE = 8'h7C;

   typedef enum logic [2:0] {
      ST_ARB,
      ST_SKP_SYM,
      ST_TLP_DATA,
      ST_TLP_END,
      ST_TLP_DISCARD,
      ST_DLLP_DATA,
      ST_DLLP_END,
      ST_DLLP_DISCARD
   } sched_state_t;

   typedef enum logic {
      GNT_TLP,
      GNT_DLLP
   } grant_t;

   // One lane symbol: control flag plus byte
   typedef struct packed {
      logic       k;
      logic [7:0] data;
   } sym_t;

   function automatic sym_t k_sym(input logic [7:0] code);
      k_sym.k    = 1'b1;
      k_sym.data = code;
   endfunction

   function automatic sym_t d_sym(input logic [7:0] b);
      d_sym.k    = 1'b0;
      d_sym.data = b;
   endfunction

endpackage

// File: rtl/tx_symbol_scheduler_skp_timer.sv
// SKP interval timer: counts enabled cycles and tracks owed SKP ordered sets (0..3).
// Latency: skp_owed updates the cycle after a wrap or consume.
// Backpressure: none; frozen while enb=0, consume only honoured when enabled.
module skp_timer #(
   parameter int SKP_INTERVAL = 1180
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enb,
   input  logic       consume,
   output logic [1:0] skp_owed
);

   localparam int TW = $clog2(SKP_INTERVAL);

   logic [TW-1:0] timer;
   logic          wrap;

   assign wrap = enb && (timer == TW'(SKP_INTERVAL - 1));

   // Interval counter, 0..SKP_INTERVAL-1, advancing only on enabled cycles
   always_ff @(posedge clk) begin
      if (rst)
         timer <= '0;
      else if (enb)
         timer <= wrap ? '0 : timer + 1'b1;
   end

   // Owed count: saturating increment on wrap, decrement on COM; both together cancel
   always_ff @(posedge clk) begin
      if (rst)
         skp_owed <= 2'd0;
      else if (enb) begin
         if (wrap && !consume && skp_owed != 2'd3)
            skp_owed <= skp_owed + 2'd1;
         else if (consume && !wrap && skp_owed != 2'd0)
            skp_owed <= skp_owed - 2'd1;
      end
   end

endmodule

// File: rtl/tx_symbol_scheduler.sv
// Lane symbol scheduler: frames TLP/DLLP bytes, inserts SKP sets, fills with IDLE, marks aborts with EDB.
// Latency: symbol chosen in cycle n is on tx_data/tx_k in n+1; start symbol costs one cycle before the first byte.
// Backpressure: ready is a pure function of state and enb; a missing byte mid-packet aborts with EDB and drains.
module tx_symbol_scheduler
   import pcs_symbols_pkg::*;
#(
   parameter int SKP_INTERVAL = 1180,
   parameter int SKP_COUNT    = 3
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enb,
   input  logic       tlp_valid,
   input  logic [7:0] tlp_data,
   input  logic       tlp_last,
   output logic       tlp_ready,
   input  logic       dllp_valid,
   input  logic [7:0] dllp_data,
   input  logic       dllp_last,
   output logic       dllp_ready,
   output logic [7:0] tx_data,
   output logic       tx_k,
   output logic       tx_valid,
   output logic       err_underrun,
   output logic [1:0] skp_owed
);

   sched_state_t state, state_nxt;
   grant_t       last_grant, grant_nxt;
   logic [2:0]   skp_cnt, skp_cnt_nxt;
   sym_t         sym_nxt;
   logic         err_nxt;
   logic         consume;
   logic         skp_due;
   logic         pick_dllp;
   logic         pick_tlp;

   skp_timer #(
      .SKP_INTERVAL(SKP_INTERVAL)
   ) u_skp_timer (
      .clk      (clk),
      .rst      (rst),
      .enb      (enb),
      .consume  (consume),
      .skp_owed (skp_owed)
   );

   assign tlp_ready  = enb && (state == ST_TLP_DATA  || state == ST_TLP_DISCARD);
   assign dllp_ready = enb && (state == ST_DLLP_DATA || state == ST_DLLP_DISCARD);

   // Clock compensation always wins arbitration; owed sets drain before any new grant
   assign skp_due   = (skp_owed != 2'd0);
   assign consume   = enb && (state == ST_ARB) && skp_due;
   // Round-robin between sources when both are ready to start
   assign pick_dllp = dllp_valid && (!tlp_valid || last_grant == GNT_TLP);
   assign pick_tlp  = tlp_valid && !pick_dllp;

   // State register: everything freezes while enb is low
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_ARB;
         last_grant <= GNT_TLP;
         skp_cnt    <= 3'd0;
      end else if (enb) begin
         state      <= state_nxt;
         last_grant <= grant_nxt;
         skp_cnt    <= skp_cnt_nxt;
      end
   end

   // Next-state: arbitration, SKP run length, packet framing and abort drain
   always_comb begin
      state_nxt   = state;
      grant_nxt   = last_grant;
      skp_cnt_nxt = skp_cnt;
      case (state)
         ST_ARB: begin
            if (skp_due) begin
               state_nxt   = ST_SKP_SYM;
               skp_cnt_nxt = 3'd0;
            end else if (pick_dllp) begin
               state_nxt = ST_DLLP_DATA;
               grant_nxt = GNT_DLLP;
            end else if (pick_tlp) begin
               state_nxt = ST_TLP_DATA;
               grant_nxt = GNT_TLP;
            end
         end
         ST_SKP_SYM: begin
            if (skp_cnt == 3'(SKP_COUNT - 1))
               state_nxt = ST_ARB;
            else
               skp_cnt_nxt = skp_cnt + 3'd1;
         end
         ST_TLP_DATA: begin
            if (!tlp_valid)
               state_nxt = ST_TLP_DISCARD;
            else if (tlp_last)
               state_nxt = ST_TLP_END;
         end
         ST_TLP_DISCARD: begin
            if (tlp_valid && tlp_last)
               state_nxt = ST_ARB;
         end
         ST_DLLP_DATA: begin
            if (!dllp_valid)
               state_nxt = ST_DLLP_DISCARD;
            else if (dllp_last)
               state_nxt = ST_DLLP_END;
         end
         ST_DLLP_DISCARD: begin
            if (dllp_valid && dllp_last)
               state_nxt = ST_ARB;
         end
         default: state_nxt = ST_ARB;   // both END states return to arbitration
      endcase
   end

   // Output decode: the symbol to emit this cycle and the underrun flag
   always_comb begin
      sym_nxt = k_sym(K_IDLE);
      err_nxt = 1'b0;
      case (state)
         ST_ARB: begin
            if (skp_due)
               sym_nxt = k_sym(K_COM);
            else if (pick_dllp)
               sym_nxt = k_sym(K_SDP);
            else if (pick_tlp)
               sym_nxt = k_sym(K_STP);
         end
         ST_SKP_SYM: sym_nxt = k_sym(K_SKP);
         ST_TLP_DATA: begin
            if (tlp_valid)
               sym_nxt = d_sym(tlp_data);
            else begin
               sym_nxt = k_sym(K_EDB);
               err_nxt = 1'b1;
            end
         end
         ST_DLLP_DATA: begin
            if (dllp_valid)
               sym_nxt = d_sym(dllp_data);
            else begin
               sym_nxt = k_sym(K_EDB);
               err_nxt = 1'b1;
            end
         end
         ST_TLP_END, ST_DLLP_END: sym_nxt = k_sym(K_END);
         default: sym_nxt = k_sym(K_IDLE);   // discard states fill with IDLE
      endcase
   end

   // Registered lane outputs; symbol holds and valid drops while disabled
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_data      <= 8'h00;
         tx_k         <= 1'b0;
         tx_valid     <= 1'b0;
         err_underrun <= 1'b0;
      end else begin
         tx_valid     <= enb;
         err_underrun <= enb && err_nxt;
         if (enb) begin
            tx_data <= sym_nxt.data;
            tx_k    <= sym_nxt.k;
         end
      end
   end

endmodule

// File: tb/tb_tx_symbol_scheduler.sv
// Directed bench for tx_symbol_scheduler with a symbol scoreboard.
// Latency: expected symbols are queued ahead and matched as tx_valid symbols appear.
// Backpressure: source models hold each byte until valid & ready is seen.
module tb_tx_symbol_scheduler;

   localparam logic [7:0] C_COM = 8'hBC, C_STP = 8'hFB, C_SDP = 8'h5C, C_SKP = 8'h1C;
   localparam logic [7:0] C_END = 8'hFD, C_EDB = 8'hFE, C_IDL = 8'h7C;

   logic       clk = 1'b0;
   logic       rst, enb;
   logic       tlp_valid, tlp_last, tlp_ready;
   logic [7:0] tlp_data;
   logic       dllp_valid, dllp_last, dllp_ready;
   logic [7:0] dllp_data;
   logic [7:0] tx_data;
   logic       tx_k, tx_valid, err_underrun;
   logic [1:0] skp_owed;

   tx_symbol_scheduler #(.SKP_INTERVAL(16), .SKP_COUNT(3)) dut (
      .clk(clk), .rst(rst), .enb(enb),
      .tlp_valid(tlp_valid), .tlp_data(tlp_data), .tlp_last(tlp_last), .tlp_ready(tlp_ready),
      .dllp_valid(dllp_valid), .dllp_data(dllp_data), .dllp_last(dllp_last), .dllp_ready(dllp_ready),
      .tx_data(tx_data), .tx_k(tx_k), .tx_valid(tx_valid),
      .err_underrun(err_underrun), .skp_owed(skp_owed)
   );

   always #5 clk = ~clk;

   int         n_chk = 0;
   int         n_err = 0;
   logic [9:0] sb[$];          // {err_underrun, tx_k, tx_data}
   logic [7:0] t_pkt[$];
   logic [7:0] d_pkt[$];
   int         t_idx, d_idx, t_gap_at, t_gap_left, t_rdy_cnt;
   logic       t_acc, d_acc, enb_tog, mon_on, exp_v;

   function automatic logic [9:0] ks(input logic [7:0] c);
      return {2'b01, c};
   endfunction

   function automatic logic [9:0] ds(input logic [7:0] c);
      return {2'b00, c};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      assert (got === exp) else begin
         n_err++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic drive_sources();
      tlp_valid = (t_idx < t_pkt.size()) && !(t_idx == t_gap_at && t_gap_left > 0);
      tlp_data  = 8'h00;
      tlp_last  = 1'b0;
      if (tlp_valid) begin
         tlp_data = t_pkt[t_idx];
         tlp_last = (t_idx == t_pkt.size() - 1);
      end
      dllp_valid = (d_idx < d_pkt.size());
      dllp_data  = 8'h00;
      dllp_last  = 1'b0;
      if (dllp_valid) begin
         dllp_data = d_pkt[d_idx];
         dllp_last = (d_idx == d_pkt.size() - 1);
      end
   endtask

   // One clock: sample handshakes at negedge, advance sources after posedge
   task automatic cycle();
      @(negedge clk);
      if (!enb) begin
         chk("tlp_ready_disabled", tlp_ready, 0);
         chk("dllp_ready_disabled", dllp_ready, 0);
      end
      if (tlp_ready) t_rdy_cnt++;
      t_acc = tlp_valid & tlp_ready;
      d_acc = dllp_valid & dllp_ready;
      if (!tlp_valid && t_idx == t_gap_at && t_gap_left > 0) t_gap_left--;
      @(posedge clk);
      #1;
      if (t_acc) t_idx++;
      if (d_acc) d_idx++;
      if (enb_tog) enb = ~enb;
      drive_sources();
   endtask

   task automatic clear_sources();
      t_pkt.delete();
      d_pkt.delete();
      t_idx = 0; d_idx = 0; t_gap_at = -1; t_gap_left = 0;
      drive_sources();
   endtask

   task automatic do_reset();
      rst = 1'b1; enb = 1'b0; enb_tog = 1'b0;
      clear_sources();
      cycle();
      cycle();
      chk("rst_tx_data", tx_data, 0);
      chk("rst_tx_k", tx_k, 0);
      chk("rst_tx_valid", tx_valid, 0);
      chk("rst_err", err_underrun, 0);
      chk("rst_skp_owed", skp_owed, 0);
      rst = 1'b0;
      t_rdy_cnt = 0;
   endtask

   task automatic finish_scn(input string tag);
      enb = 1'b0; enb_tog = 1'b0;
      clear_sources();
      cycle();
      cycle();
      chk(tag, sb.size(), 0);
      sb.delete();
   endtask

   task automatic mon_step();
      logic [9:0] got;
      logic [9:0] exp;
      chk("tx_valid", tx_valid, exp_v);
      if (tx_valid) begin
         got = {err_underrun, tx_k, tx_data};
         n_chk++;
         assert (sb.size() != 0) else begin
            n_err++;
            $error("FAIL sb_extra: got %h expected none", got);
         end
         if (sb.size() != 0) begin
            exp = sb.pop_front();
            chk("symbol", got, exp);
         end
      end else begin
         chk("err_when_idle", err_underrun, 0);
      end
      exp_v = enb & ~rst;
   endtask

   initial begin
      rst = 1'b1; enb = 1'b0; enb_tog = 1'b0; mon_on = 1'b0; exp_v = 1'b0;
      t_rdy_cnt = 0;
      clear_sources();
      fork
         forever begin
            @(negedge clk);
            if (mon_on) mon_step();
         end
      join_none
      repeat (2) begin @(posedge clk); #1; end
      chk("init_tx_data", tx_data, 0);
      chk("init_tx_k", tx_k, 0);
      chk("init_tx_valid", tx_valid, 0);
      chk("init_skp_owed", skp_owed, 0);
      chk("init_tlp_ready", tlp_ready, 0);
      chk("init_dllp_ready", dllp_ready, 0);
      mon_on = 1'b1;

      // Idle: no sources, IDLE every enabled cycle
      rst = 1'b0; enb = 1'b1;
      repeat (6) sb.push_back(ks(C_IDL));
      repeat (6) cycle();
      finish_scn("idle_drained");

      // Single 4-byte TLP
      do_reset();
      t_pkt = '{8'h11, 8'h22, 8'h33, 8'h44};
      drive_sources(); enb = 1'b1;
      sb.push_back(ks(C_STP));
      sb.push_back(ds(8'h11)); sb.push_back(ds(8'h22));
      sb.push_back(ds(8'h33)); sb.push_back(ds(8'h44));
      sb.push_back(ks(C_END)); sb.push_back(ks(C_IDL));
      repeat (7) cycle();
      chk("tlp_ready_cycles", t_rdy_cnt, 4);
      chk("tlp_all_taken", t_idx, 4);
      finish_scn("tlp4_drained");

      // Both valid from reset: DLLP first, TLP back-to-back after END
      do_reset();
      d_pkt = '{8'hD1, 8'hD2};
      t_pkt = '{8'hE1, 8'hE2};
      drive_sources(); enb = 1'b1;
      sb.push_back(ks(C_SDP)); sb.push_back(ds(8'hD1)); sb.push_back(ds(8'hD2)); sb.push_back(ks(C_END));
      sb.push_back(ks(C_STP)); sb.push_back(ds(8'hE1)); sb.push_back(ds(8'hE2)); sb.push_back(ks(C_END));
      sb.push_back(ks(C_IDL));
      repeat (9) cycle();
      finish_scn("both_drained");

      // Underrun after 2 of 5 bytes: EDB, then IDLE while the rest drains
      do_reset();
      t_pkt = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
      t_gap_at = 2; t_gap_left = 1;
      drive_sources(); enb = 1'b1;
      sb.push_back(ks(C_STP)); sb.push_back(ds(8'hA0)); sb.push_back(ds(8'hA1));
      sb.push_back({2'b11, C_EDB});
      repeat (4) sb.push_back(ks(C_IDL));
      repeat (8) cycle();
      chk("underrun_drain_taken", t_idx, 5);
      finish_scn("underrun_drained");

      // 40-byte TLP across two SKP intervals: sets deferred then drained
      do_reset();
      for (int i = 0; i < 40; i++) t_pkt.push_back(8'(i * 7 + 1));
      drive_sources(); enb = 1'b1;
      sb.push_back(ks(C_STP));
      for (int i = 0; i < 40; i++) sb.push_back(ds(8'(i * 7 + 1)));
      sb.push_back(ks(C_END));
      // two owed sets, then a third interval expires while draining
      repeat (3) begin
         sb.push_back(ks(C_COM));
         repeat (3) sb.push_back(ks(C_SKP));
      end
      sb.push_back(ks(C_IDL));
      repeat (41) cycle();
      chk("skp_owed_at_end", skp_owed, 2);
      repeat (14) cycle();
      chk("skp_owed_drained", skp_owed, 0);
      finish_scn("skp_drained");

      // enb toggling during a DLLP: same symbol stream, gaps in tx_valid
      do_reset();
      d_pkt = '{8'hB1, 8'hB2, 8'hB3};
      drive_sources(); enb = 1'b1; enb_tog = 1'b1;
      sb.push_back(ks(C_SDP)); sb.push_back(ds(8'hB1)); sb.push_back(ds(8'hB2));
      sb.push_back(ds(8'hB3)); sb.push_back(ks(C_END)); sb.push_back(ks(C_IDL));
      repeat (12) cycle();
      chk("toggle_all_taken", d_idx, 3);
      finish_scn("toggle_drained");

      // rst mid-DLLP: immediate reset outputs, then a clean restart
      do_reset();
      d_pkt = '{8'hC1, 8'hC2, 8'hC3};
      drive_sources(); enb = 1'b1;
      sb.push_back(ks(C_SDP)); sb.push_back(ds(8'hC1));
      repeat (2) cycle();
      rst = 1'b1;
      cycle();
      chk("midrst_tx_data", tx_data, 0);
      chk("midrst_tx_k", tx_k, 0);
      chk("midrst_tx_valid", tx_valid, 0);
      chk("midrst_dllp_ready", dllp_ready, 0);
      rst = 1'b0;
      d_idx = 0;
      drive_sources();
      sb.push_back(ks(C_SDP)); sb.push_back(ds(8'hC1)); sb.push_back(ds(8'hC2));
      sb.push_back(ds(8'hC3)); sb.push_back(ks(C_END)); sb.push_back(ks(C_IDL));
      repeat (6) cycle();
      finish_scn("midrst_drained");

      mon_on = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
